// File: rtl/text_dump_tx_pkg.sv
// Shared constants, FSM encoding and character filter for the text-buffer UART dump.
// Pure definitions: no latency and no flow control of its own.
package text_dump_tx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10416;
  localparam int COLS = 32;
  localparam int ROWS = 4;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_SUB = 8'h2E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_LOAD,
    S_SEND,
    S_CR,
    S_LF,
    S_DONE
  } state_t;

  // Control codes, DEL and high-bit bytes would upset a terminal, so they print as '.'
  function automatic logic [7:0] printable(input logic [7:0] c);
    return ((c < 8'h20) || (c == 8'h7F) || c[7]) ? ASCII_SUB : c;
  endfunction

endpackage

// File: rtl/text_dump_tx_serializer.sv
// 8N1 UART serializer: a frame starts on the edge after load while ready, 10*CLKS_PER_BIT cycles long.
// load is ignored while a frame is in flight; ready returns high the cycle after the stop bit.
module uart_tx_serializer
  import text_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CELL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic [9:0]    r_frame;
  logic          r_active;
  logic          r_tx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_frame  <= '1;
      r_active <= 1'b0;
      r_tx     <= 1'b1;
    end else if (!r_active) begin
      if (load) begin
        r_frame  <= {1'b1, data, 1'b0};
        r_active <= 1'b1;
        r_tx     <= 1'b0;
        r_cnt    <= '0;
        r_idx    <= '0;
      end
    end else if (r_cnt == LAST_CELL) begin
      r_cnt <= '0;
      if (r_idx == 4'd9) begin
        r_active <= 1'b0;
        r_tx     <= 1'b1;
        r_idx    <= '0;
      end else begin
        r_idx <= r_idx + 4'd1;
        r_tx  <= r_frame[r_idx + 4'd1];
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tx    = r_tx;
  assign ready = !r_active;

endmodule

// File: rtl/text_dump_tx.sv
// Dumps the 32x4 text buffer over UART, one row per line ending CR LF; ~136*10 bit times per dump.
// start is accepted only in IDLE; the RAM address is held steady while each byte shifts out.
module text_dump_tx
  import text_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] ry,
  output logic [4:0] rx,
  input  logic [7:0] rdata,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  state_t     r_state, w_state_n;
  logic [1:0] r_ry, w_ry_n;
  logic [4:0] r_rx, w_rx_n;
  logic       r_launched, w_launched_n;
  logic       w_load;
  logic [7:0] w_data;
  logic       w_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ry       <= '0;
      r_rx       <= '0;
      r_launched <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_ry       <= w_ry_n;
      r_rx       <= w_rx_n;
      r_launched <= w_launched_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_ry_n       = r_ry;
    w_rx_n       = r_rx;
    w_launched_n = r_launched;
    w_load       = 1'b0;
    w_data       = ASCII_SUB;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_ry_n    = '0;
          w_rx_n    = '0;
          w_state_n = S_RD_WAIT;
        end
      end
      S_RD_WAIT: w_state_n = S_LOAD;
      S_LOAD: begin
        w_load    = 1'b1;
        w_data    = printable(rdata);
        w_state_n = S_SEND;
      end
      S_SEND: begin
        if (w_ready) begin
          if (r_rx == 5'(COLS - 1)) begin
            w_state_n = S_CR;
          end else begin
            w_rx_n    = r_rx + 5'd1;
            w_state_n = S_RD_WAIT;
          end
        end
      end
      // CR and LF each launch once, then wait for the serializer to drain
      S_CR: begin
        w_data = ASCII_CR;
        if (w_ready) begin
          if (!r_launched) begin
            w_load       = 1'b1;
            w_launched_n = 1'b1;
          end else begin
            w_launched_n = 1'b0;
            w_state_n    = S_LF;
          end
        end
      end
      S_LF: begin
        w_data = ASCII_LF;
        if (w_ready) begin
          if (!r_launched) begin
            w_load       = 1'b1;
            w_launched_n = 1'b1;
          end else begin
            w_launched_n = 1'b0;
            if (r_ry == 2'(ROWS - 1)) begin
              w_state_n = S_DONE;
            end else begin
              w_ry_n    = r_ry + 2'd1;
              w_rx_n    = '0;
              w_state_n = S_RD_WAIT;
            end
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .reset(reset),
    .load (w_load),
    .data (w_data),
    .tx   (tx),
    .ready(w_ready)
  );

  assign ry   = r_ry;
  assign rx   = r_rx;
  assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_text_dump_tx.sv
// Directed bench for text_dump_tx: RAM model with registered read, UART decoder, per-byte checks.
module tb_text_dump_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] ry;
  logic [4:0] rx;
  logic [7:0] rdata;
  logic       tx, busy, done;

  int n_assert = 0;
  int n_fail = 0;
  int frame_err = 0;
  logic [7:0] q[$];
  logic [7:0] mem [4][32];

  always #5 clk = ~clk;

  text_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .ry   (ry),
    .rx   (rx),
    .rdata(rdata),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always @(posedge clk) rdata <= mem[ry][rx];

  // UART receiver sampling each bit 2.5 clocks into its cell
  initial begin
    logic [7:0] b;
    logic       stop;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (2) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
          end
          repeat (CPB) @(negedge clk);
          stop = tx;
          q.push_back(b);
          if (stop !== 1'b1) frame_err++;
        end
      end
    end
  end

  function automatic logic [7:0] exp_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) return c;
    return 8'h2E;
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    int r, p;
    r = k / 34;
    p = k % 34;
    if (p < 32) return exp_char(mem[r][p]);
    if (p == 32) return 8'h0D;
    return 8'h0A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_dump(input bit do_start, input bit spam, input bit chain);
    int   done_seen = 0;
    int   cyc = 0;
    int   f = 63;
    bit   got = 0;
    logic wave [64];
    logic [9:0] fr;
    q.delete();
    frame_err = 0;
    for (int i = 0; i < 64; i++) wave[i] = 1'b1;
    if (do_start) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      wave[0] = tx;
      cyc = 1;
    end
    while (!got && cyc < 12000) begin
      @(negedge clk);
      if (cyc < 64) wave[cyc] = tx;
      cyc++;
      if (spam) start = (cyc % 53 == 0);
      if (done === 1'b1) begin
        done_seen++;
        got = 1;
      end
    end
    start = 1'b0;
    check("done_within_budget", {31'd0, got}, 32'd1);
    if (chain) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (17) begin
        @(negedge clk);
        if (done === 1'b1) done_seen++;
      end
    end else begin
      repeat (20) begin
        @(negedge clk);
        if (done === 1'b1) done_seen++;
      end
      check("busy_after_done", {31'd0, busy}, 32'd0);
    end
    check("byte_count", q.size(), 32'd136);
    check("done_pulses", done_seen, 32'd1);
    check("frame_errors", frame_err, 32'd0);
    for (int k = 0; k < 136; k++)
      check($sformatf("byte_%0d", k), {24'd0, (k < q.size()) ? q[k] : 8'hxx}, {24'd0, exp_byte(k)});
    if (do_start) begin
      for (int i = 63; i >= 0; i--) if (wave[i] === 1'b0) f = i;
      check("first_fall_within_3", {31'd0, (f <= 3)}, 32'd1);
      check("idle_before_start_bit", {31'd0, wave[f-1]}, 32'd1);
      fr = {1'b1, exp_byte(0), 1'b0};
      for (int k = 0; k < 40; k++)
        if (f + k < 64)
          check($sformatf("bit_level_%0d", k), {31'd0, wave[f+k]}, {31'd0, fr[k/CPB]});
    end
  endtask

  initial begin
    int t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++)
        mem[r][c] = 8'(8'h41 + c);

    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ry", {30'd0, ry}, 32'd0);
      check("rst_rx", {27'd0, rx}, 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_dump(1'b1, 1'b0, 1'b0);

    // Rows differ, covering DEL and high-bit bytes, plus hand-picked cells
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++)
        mem[r][c] = 8'(8'h21 + r * 32 + c);
    mem[0][0] = 8'h55;
    mem[1][3] = 8'h00;
    mem[1][4] = 8'h7F;
    mem[1][5] = 8'h85;
    mem[1][6] = 8'h20;

    run_dump(1'b1, 1'b1, 1'b1);
    check("sub_00", {24'd0, q[37]}, 32'h2E);
    check("sub_7f", {24'd0, q[38]}, 32'h2E);
    check("sub_85", {24'd0, q[39]}, 32'h2E);
    check("keep_20", {24'd0, q[40]}, 32'h20);
    check("first_55", {24'd0, q[0]}, 32'h55);
    run_dump(1'b0, 1'b0, 1'b0);

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t = 0;
    while (!(ry == 2'd2 && tx === 1'b0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("reach_row2", {31'd0, (t < 20000)}, 32'd1);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ry", {30'd0, ry}, 32'd0);
    check("midrst_rx", {27'd0, rx}, 32'd0);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    run_dump(1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/text_dump_tx.md
Name: text_dump_tx

Overview:
- Reads the 32x4 character text buffer through the RAM's read port and transmits it over the UART TX line as 8N1 serial.
- This is the readback counterpart of the UART-receive write path that fills the buffer.
- One dump is started by a single-cycle start pulse.
- Output is row by row, each row terminated by CR LF, so a terminal mirrors the VGA text screen.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per UART bit (100 MHz / 9600 baud).
- COLS, 32, characters per row; column address width is 5.
- ROWS, 4, rows in buffer; row address width is 2.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-low reset (reset==0 resets on posedge clk)
- start  input  1  single-cycle request to begin a dump
- ry  output  2  RAM read row address
- rx  output  5  RAM read column address
- rdata  input  8  RAM read data, valid 1 clk after ry/rx change (registered read)
- tx  output  1  UART serial out, idles high
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  single-cycle pulse when the final LF stop bit completes

Behaviour:
- Reset values (reset==0): tx=1, busy=0, done=0, ry=0, rx=0, FSM=IDLE, bit counters=0. Reset mid-frame aborts the dump; tx is high the cycle after reset.
- FSM states:
  - IDLE: start=1 → set ry=0, rx=0, busy=1 → RD_WAIT.
  - RD_WAIT: one cycle for RAM latency → LOAD.
  - LOAD: latch rdata, substitute if needed → SEND.
  - SEND: serializer transmitting. When the byte completes, the next state depends on position:
    - rx<COLS-1: rx+1 → RD_WAIT.
    - rx==COLS-1: → CR.
  - CR: send 0x0D, then → LF.
  - LF: send 0x0A. If ry<ROWS-1: ry+1, rx=0 → RD_WAIT. If ry==ROWS-1: → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Character substitution: rdata<0x20, rdata==0x7F, or rdata[7]==1 → transmit 0x2E ('.'). Otherwise transmit rdata unchanged.
- Serial frame:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - The serializer's bit-cell counter reloads at each bit boundary; the next byte's start bit may follow the previous stop bit back-to-back.
- Totals: ROWS*(COLS+2)=136 bytes per dump. Dump length is 136*10*CLKS_PER_BIT cycles plus a fixed per-byte overhead of ≤3 cycles.
- start while busy=1 is ignored, not queued. start in the same cycle as done is also ignored; a new dump needs start with busy=0 in the IDLE state.
- ry/rx change only at the transitions listed above. They are stable while a byte is shifting, so the RAM write port may operate concurrently without affecting the byte in flight.
- The RAM is sampled once per character. Writes to a cell after it has been read are not reflected in the current dump.
- Counter widths: the bit-cell counter is sized to $clog2(CLKS_PER_BIT). Bit index is 4 bits, counting 0..9 with no wrap beyond 9.

Decomposition:
- Shared package holds:
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_SUB=8'h2E;
  - FSM state encoding;
  - default CLKS_PER_BIT.
- One sub-module, uart_tx_serializer, with ports clk, reset, load, data[7:0], tx, ready.
  - It owns the frame timing.
  - text_dump_tx owns addressing, substitution and the CR/LF sequencing.

Test Plan (CLKS_PER_BIT=4 in simulation; RAM model has 1-cycle read latency):
- Reset with reset=0 for 3 clks → tx=1, busy=0, done=0, ry=0, rx=0 throughout. Then pulse start → busy=1 next cycle; first falling tx edge within 3 clks.
- RAM preloaded: row r col c = 0x41+c (wrapping within printable range); start → decoded stream is 136 bytes. Each row is 32 chars, then 0x0D 0x0A; done pulses exactly once after the last stop bit, then busy=0.
- RAM cells holding 0x00, 0x7F, 0x85, 0x20 → transmitted as 0x2E, 0x2E, 0x2E, 0x20.
- Bit timing check for byte 0x55: tx levels are 0,1,0,1,0,1,0,1,0,1, each held exactly 4 clks.
- start pulsed repeatedly mid-dump → still exactly 136 bytes and one done pulse. start 1 clk after done → a second complete dump.
- reset=0 asserted during a data bit of row 2 → tx=1 next cycle, busy=0, ry=rx=0. A following start produces a full dump from row 0 col 0.
